// File: rtl/wisc_pkg.sv
// wisc_pkg: shared decode constants for the register-destination path.
package wisc_pkg;

  localparam int unsigned WISC_NREG = 8;
  localparam int unsigned REGW      = $clog2(WISC_NREG);
  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned REGDST_W  = 2;

  // Instruction field bit positions
  localparam int unsigned RS_HI = 10;
  localparam int unsigned RS_LO = 8;
  localparam int unsigned RT_HI = 7;
  localparam int unsigned RT_LO = 5;
  localparam int unsigned RD_HI = 4;
  localparam int unsigned RD_LO = 2;

  localparam logic [REGW-1:0] R7_IDX = REGW'(7);

  typedef enum logic [REGDST_W-1:0] {
    REGDST_RD = 2'b00,
    REGDST_RT = 2'b01,
    REGDST_RS = 2'b10,
    REGDST_R7 = 2'b11
  } regdst_e;

endpackage

// File: rtl/dest_resolve.sv
// dest_resolve: maps the decode destination select plus instruction word to a register number.
module dest_resolve
  import wisc_pkg::*;
(
  input  logic [REGDST_W-1:0] regdst_i,
  input  logic [INSTR_W-1:0]  instr_i,
  output logic [REGW-1:0]     dest_c_o
);

  // Opcode and function bits never name a register
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_i[INSTR_W-1:RS_HI+1], instr_i[RD_LO-1:0]};

  // Select the destination field
  always_comb begin
    dest_c_o = '0;
    case (regdst_e'(regdst_i))
      REGDST_RD: dest_c_o = instr_i[RD_HI:RD_LO];
      REGDST_RT: dest_c_o = instr_i[RT_HI:RT_LO];
      REGDST_RS: dest_c_o = instr_i[RS_HI:RS_LO];
      REGDST_R7: dest_c_o = R7_IDX;
      default:   dest_c_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_dest_tracker.sv
// wb_dest_tracker: carries resolved write destinations from issue to write-back,
// stalls issue on RAW hazards and drives the register-file write port.
// Optional build macro: WB_BYPASS_EN -- the register file writes before it reads,
// so a match only in the write-back stage does not stall.
module wb_dest_tracker
  import wisc_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned NREG  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iss_valid,
  input  logic                    iss_regwr,
  input  logic [REGDST_W-1:0]     iss_regdst,
  input  logic [INSTR_W-1:0]      iss_instr,
  input  logic                    iss_rs_use,
  input  logic                    iss_rt_use,
  output logic                    iss_stall,
  input  logic                    pipe_hold,
  input  logic                    flush,
  output logic                    rf_wr_en,
  output logic [$clog2(NREG)-1:0] rf_wr_sel,
  output logic [2:0]              inflight
);

  localparam int unsigned RW   = $clog2(NREG);
  localparam int unsigned CNTW = 3;
`ifdef WB_BYPASS_EN
  localparam int unsigned HAZ_STAGES = DEPTH - 1;
`else
  localparam int unsigned HAZ_STAGES = DEPTH;
`endif

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [RW-1:0]    dst_q [DEPTH];
  logic [RW-1:0]    dst_d [DEPTH];
  logic [CNTW-1:0]  inflight_q, inflight_d;
  logic [REGW-1:0]  res_dest;
  logic [RW-1:0]    rs_sel;
  logic [RW-1:0]    rt_sel;
  logic             hazard;
  logic             accept;

  function automatic logic [CNTW-1:0] count_valid(input logic [DEPTH-1:0] v);
    logic [CNTW-1:0] n;
    n = '0;
    for (int unsigned k = 0; k < DEPTH; k++) n = n + CNTW'(v[k]);
    return n;
  endfunction

  dest_resolve u_dest_resolve (
    .regdst_i (iss_regdst),
    .instr_i  (iss_instr),
    .dest_c_o (res_dest)
  );

  assign rs_sel = RW'(iss_instr[RS_HI:RS_LO]);
  assign rt_sel = RW'(iss_instr[RT_HI:RT_LO]);

  // RAW check of the incoming source fields against every live destination
  always_comb begin
    hazard = 1'b0;
    for (int unsigned k = 0; k < HAZ_STAGES; k++) begin
      if (vld_q[k] && ((iss_rs_use && (dst_q[k] == rs_sel)) ||
                       (iss_rt_use && (dst_q[k] == rt_sel)))) begin
        hazard = 1'b1;
      end
    end
  end

  assign iss_stall = pipe_hold | (iss_valid & hazard);
  assign accept    = iss_valid & ~iss_stall & ~flush & ~pipe_hold;

  // Stage advance: load at stage 0, shift down, flush squashes everything heading past WB
  always_comb begin
    vld_d = vld_q;
    dst_d = dst_q;
    if (!pipe_hold) begin
      vld_d[0] = accept & iss_regwr;
      dst_d[0] = RW'(res_dest);
      for (int unsigned k = 1; k < DEPTH; k++) begin
        vld_d[k] = vld_q[k-1] & ~flush;
        dst_d[k] = dst_q[k-1];
      end
    end
    inflight_d = count_valid(vld_d);
  end

  // Stage registers and in-flight count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      inflight_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) dst_q[k] <= '0;
    end else begin
      vld_q      <= vld_d;
      dst_q      <= dst_d;
      inflight_q <= inflight_d;
    end
  end

  // The write-back stage owns the register-file port; a hold blocks the write
  assign rf_wr_en  = vld_q[DEPTH-1] & ~pipe_hold;
  assign rf_wr_sel = dst_q[DEPTH-1];
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_wb_dest_tracker.sv
// tb_wb_dest_tracker: directed bench with an age-list model of in-flight writes.
module tb_wb_dest_tracker;

  localparam int unsigned DEPTH = 3;
  localparam int unsigned NREG  = 8;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int HAZ_STALLS = BYP ? 2 : 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid = 1'b0;
  logic        iss_regwr = 1'b0;
  logic [1:0]  iss_regdst = 2'b00;
  logic [15:0] iss_instr = 16'h0;
  logic        iss_rs_use = 1'b0;
  logic        iss_rt_use = 1'b0;
  logic        pipe_hold = 1'b0;
  logic        flush = 1'b0;
  logic        iss_stall;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_sel;
  logic [2:0]  inflight;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  wb_dest_tracker #(.DEPTH(DEPTH), .NREG(NREG)) dut (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (iss_valid),
    .iss_regwr  (iss_regwr),
    .iss_regdst (iss_regdst),
    .iss_instr  (iss_instr),
    .iss_rs_use (iss_rs_use),
    .iss_rt_use (iss_rt_use),
    .iss_stall  (iss_stall),
    .pipe_hold  (pipe_hold),
    .flush      (flush),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_sel  (rf_wr_sel),
    .inflight   (inflight)
  );

  // ---------------- model: list of pending writes with their age since issue
  typedef struct {
    logic [2:0]  dest;
    int unsigned age;
  } ent_t;
  ent_t mq[$];
  ent_t nq[$];

  function automatic logic [2:0] m_resolve(input logic [1:0] sel, input logic [15:0] ins);
    case (sel)
      2'b00:   return ins[4:2];
      2'b01:   return ins[7:5];
      2'b10:   return ins[10:8];
      default: return 3'd7;
    endcase
  endfunction

  function automatic bit m_stall();
    bit hz;
    hz = 1'b0;
    foreach (mq[i]) begin
      if (!(BYP && mq[i].age == DEPTH-1)) begin
        if ((iss_rs_use && mq[i].dest == iss_instr[10:8]) ||
            (iss_rt_use && mq[i].dest == iss_instr[7:5])) hz = 1'b1;
      end
    end
    return pipe_hold || (iss_valid && hz);
  endfunction

  function automatic bit m_wr_en();
    bit e;
    e = 1'b0;
    foreach (mq[i]) if (mq[i].age == DEPTH-1) e = 1'b1;
    return e && !pipe_hold;
  endfunction

  function automatic logic [2:0] m_wr_sel();
    logic [2:0] s;
    s = 3'd0;
    foreach (mq[i]) if (mq[i].age == DEPTH-1) s = mq[i].dest;
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else if (!pipe_hold) begin
      bit acc;
      acc = iss_valid && !m_stall() && !flush;
      nq.delete();
      foreach (mq[i])
        if (!flush && mq[i].age < DEPTH-1) nq.push_back('{dest: mq[i].dest, age: mq[i].age + 1});
      if (acc && iss_regwr) nq.push_back('{dest: m_resolve(iss_regdst, iss_instr), age: 0});
      mq = nq;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_iss_stall", 32'(iss_stall), 32'(m_stall()));
      check("cyc_rf_wr_en", 32'(rf_wr_en), 32'(m_wr_en()));
      if (m_wr_en()) check("cyc_rf_wr_sel", 32'(rf_wr_sel), 32'(m_wr_sel()));
      check("cyc_inflight", 32'(inflight), 32'(mq.size()));
    end
  end

  // ---------------- stimulus helpers
  task automatic put(input logic v, input logic wr, input logic [1:0] dst,
                     input logic [15:0] ins, input logic rs, input logic rt);
    iss_valid  = v;
    iss_regwr  = wr;
    iss_regdst = dst;
    iss_instr  = ins;
    iss_rs_use = rs;
    iss_rt_use = rt;
  endtask

  task automatic idle();
    put(1'b0, 1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
    flush     = 1'b0;
    pipe_hold = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (DEPTH + 2) cyc();
  endtask

  task automatic hazard_run(input logic [1:0] wdst, input logic [15:0] wins,
                            input logic [15:0] rins, input logic rs, input logic rt,
                            output int stalls, output bit acc);
    stalls = 0;
    acc    = 1'b0;
    put(1'b1, 1'b1, wdst, wins, 1'b0, 1'b0);
    cyc();
    put(1'b1, 1'b0, 2'b00, rins, rs, rt);
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge clk);
      if (iss_stall) stalls++;
      else acc = 1'b1;
      cyc();
    end
    idle();
    drain();
  endtask

  // ---------------- directed tests
  initial begin
    int          lat;
    int          pulses;
    int          stalls;
    bit          acc;
    bit          found;
    logic [2:0]  wr_log[$];
    logic [2:0]  inf_log[8];

    // reset and release
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("t1_stall_release", 32'(iss_stall), 32'd0);
    check("t1_wr_en_reset", 32'(rf_wr_en), 32'd0);
    check("t1_wr_sel_reset", 32'(rf_wr_sel), 32'd0);
    check("t1_inflight_reset", 32'(inflight), 32'd0);
    chk_en = 1'b1;
    cyc();

    // ADD Rd=5, latency to write-back
    put(1'b1, 1'b1, 2'b00, 16'h0014, 1'b0, 1'b0);
    lat = 0;
    found = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rf_wr_en && !found) begin
        found = 1'b1;
        lat   = c;
        check("t2_wr_sel", 32'(rf_wr_sel), 32'd5);
      end
      cyc();
      if (c == 0) idle();
    end
    check("t2_latency", 32'(lat), 32'(DEPTH));
    drain();

    // ADDI Rt=2 followed by a reader of Rs=2
    hazard_run(2'b01, 16'h0040, 16'h0200, 1'b1, 1'b0, stalls, acc);
    check("t3_rs_stalls", 32'(stalls), 32'(HAZ_STALLS));
    check("t3_accepted", 32'(acc), 32'd1);

    // Rs=6 written, read through Rt=6
    hazard_run(2'b10, 16'h0600, 16'h00C0, 1'b0, 1'b1, stalls, acc);
    check("t3_rt_stalls", 32'(stalls), 32'(HAZ_STALLS));

    // R7 written, read through Rs=7
    hazard_run(2'b11, 16'h0000, 16'h0700, 1'b1, 1'b0, stalls, acc);
    check("t3_r7_stalls", 32'(stalls), 32'(HAZ_STALLS));

    // Matching field that is not used must not stall
    hazard_run(2'b01, 16'h0040, 16'h0200, 1'b0, 1'b1, stalls, acc);
    check("t3_unused_field_stalls", 32'(stalls), 32'd0);

    // JAL to R7 then flush next cycle
    put(1'b1, 1'b1, 2'b11, 16'h1234, 1'b0, 1'b0);
    cyc();
    idle();
    flush = 1'b1;
    @(negedge clk);
    check("t4_inflight_before_flush", 32'(inflight), 32'd1);
    cyc();
    flush = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rf_wr_en) pulses++;
      cyc();
    end
    check("t4_r7_writes", 32'(pulses), 32'd0);
    check("t4_inflight_after", 32'(inflight), 32'd0);

    // Two in flight, hold for 4 cycles, then retire in order
    put(1'b1, 1'b1, 2'b00, 16'h000C, 1'b0, 1'b0);
    cyc();
    put(1'b1, 1'b1, 2'b01, 16'h00C0, 1'b0, 1'b0);
    cyc();
    idle();
    pipe_hold = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5_hold_wr_en", 32'(rf_wr_en), 32'd0);
      check("t5_hold_inflight", 32'(inflight), 32'd2);
      cyc();
    end
    pipe_hold = 1'b0;
    wr_log.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rf_wr_en) wr_log.push_back(rf_wr_sel);
      cyc();
    end
    check("t5_write_count", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("t5_first_sel", 32'(wr_log[0]), 32'd3);
      check("t5_second_sel", 32'(wr_log[1]), 32'd6);
    end

    // Back-to-back LBI to R1..R3
    wr_log.delete();
    for (int c = 0; c < 8; c++) begin
      if (c < 3) put(1'b1, 1'b1, 2'b10, 16'((c + 1) << 8), 1'b0, 1'b0);
      else idle();
      @(negedge clk);
      inf_log[c] = inflight;
      if (rf_wr_en) wr_log.push_back(rf_wr_sel);
      cyc();
    end
    check("t6_inflight_1", 32'(inf_log[1]), 32'd1);
    check("t6_inflight_2", 32'(inf_log[2]), 32'd2);
    check("t6_inflight_3", 32'(inf_log[3]), 32'd3);
    check("t6_write_count", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      check("t6_sel_0", 32'(wr_log[0]), 32'd1);
      check("t6_sel_1", 32'(wr_log[1]), 32'd2);
      check("t6_sel_2", 32'(wr_log[2]), 32'd3);
    end

    // Flush while the oldest entry sits in write-back; issue in flush cycle dropped
    wr_log.delete();
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: put(1'b1, 1'b1, 2'b00, 16'h0004, 1'b0, 1'b0);
        1: put(1'b1, 1'b1, 2'b00, 16'h0008, 1'b0, 1'b0);
        2: put(1'b1, 1'b1, 2'b00, 16'h0010, 1'b0, 1'b0);
        3: begin
          put(1'b1, 1'b1, 2'b11, 16'h0000, 1'b0, 1'b0);
          flush = 1'b1;
        end
        default: idle();
      endcase
      @(negedge clk);
      if (rf_wr_en) wr_log.push_back(rf_wr_sel);
      cyc();
    end
    check("t8_write_count", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) check("t8_sel", 32'(wr_log[0]), 32'd1);
    check("t8_inflight", 32'(inflight), 32'd0);

    // Asynchronous reset mid-cycle with writes in flight
    put(1'b1, 1'b1, 2'b00, 16'h0014, 1'b0, 1'b0);
    cyc();
    put(1'b1, 1'b1, 2'b00, 16'h000C, 1'b0, 1'b0);
    cyc();
    idle();
    cyc();
    #1;
    check("t7_wr_en_before_reset", 32'(rf_wr_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t7_wr_en_async", 32'(rf_wr_en), 32'd0);
    check("t7_inflight_async", 32'(inflight), 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("t7_stall_release", 32'(iss_stall), 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rf_wr_en) pulses++;
      cyc();
    end
    check("t7_writes_after_reset", 32'(pulses), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
